// File: rtl/axi4_bus_rd_fifos.sv
// axi4_bus_rd_fifos: AXI4-lite read-side AR/R FIFO bridge with credit-bounded outstanding reads.
// Optional rd_err_count / rd_outstanding ports when AXI4_BUS_RD_FIFOS_STATS_EN is defined.
module axi4_bus_rd_fifos #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              ar_rd_empty,
  input  logic              ar_rd_en,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [2:0]        ar_prot,
  input  logic              r_wr_en,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  output logic              r_wr_full
`ifdef AXI4_BUS_RD_FIFOS_STATS_EN
  ,
  output logic [15:0]           rd_err_count,
  output logic [$clog2(DEPTH):0] rd_outstanding
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MAX_CREDIT = (AW+1)'(DEPTH);
  logic run;
  logic [AW:0] credit, ar_wp, ar_rp, r_wp, r_rp;
  logic [ADDR_W+2:0] ar_mem [DEPTH];
  logic [DATA_W+1:0] r_mem [DEPTH];
  logic ar_empty, ar_full, r_empty, r_full, ar_hs, r_hs, ar_push, ar_pop, r_push;
  assign ar_empty = ar_wp == ar_rp;
  assign ar_full  = (ar_wp[AW] != ar_rp[AW]) && (ar_wp[AW-1:0] == ar_rp[AW-1:0]);
  assign r_empty  = r_wp == r_rp;
  assign r_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign arready  = run & (credit != '0);
  assign ar_hs    = arvalid & arready;
  assign r_hs     = rvalid & rready;
  assign ar_push  = ar_hs & ~ar_full;
  assign ar_pop   = ar_rd_en & ~ar_empty;
  assign r_push   = r_wr_en & ~r_full;
  assign ar_rd_empty = ar_empty;
  assign r_wr_full   = r_full;
  assign rvalid      = ~r_empty;
  assign {ar_addr, ar_prot} = ar_mem[ar_rp[AW-1:0]];
  assign {rdata, rresp}     = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge aclk) begin
    if (ar_push) ar_mem[ar_wp[AW-1:0]] <= {araddr, arprot};
    if (r_push) r_mem[r_wp[AW-1:0]] <= {r_data, r_resp};
  end
  // credit tracks free R slots; increment is capped so stray responses cannot inflate it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run    <= 1'b0;
      credit <= MAX_CREDIT;
      ar_wp  <= '0;
      ar_rp  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      run    <= 1'b1;
      credit <= credit - (AW+1)'(ar_hs & ~r_hs) + (AW+1)'(r_hs & ~ar_hs & (credit != MAX_CREDIT));
      ar_wp  <= ar_wp + (AW+1)'(ar_push);
      ar_rp  <= ar_rp + (AW+1)'(ar_pop);
      r_wp   <= r_wp + (AW+1)'(r_push);
      r_rp   <= r_rp + (AW+1)'(r_hs);
    end
  end
`ifdef AXI4_BUS_RD_FIFOS_STATS_EN
  assign rd_outstanding = MAX_CREDIT - credit;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_err_count <= '0;
    else if (r_hs && rresp != 2'b00 && rd_err_count != 16'hFFFF) rd_err_count <= rd_err_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_axi4_bus_rd_fifos.sv
// tb_axi4_bus_rd_fifos: randomized, model-checked bench for axi4_bus_rd_fifos.
// Stats checks compile only when AXI4_BUS_RD_FIFOS_STATS_EN is defined.
module tb_axi4_bus_rd_fifos;
  localparam int DEPTH = 4;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [31:0] araddr, rdata, r_data, ar_addr;
  logic [2:0] arprot, ar_prot;
  logic [1:0] rresp, r_resp;
  logic arvalid, arready, rvalid, rready, ar_rd_empty, ar_rd_en, r_wr_en, r_wr_full;
`ifdef AXI4_BUS_RD_FIFOS_STATS_EN
  logic [15:0] rd_err_count;
  logic [2:0] rd_outstanding;
`endif
  int total = 0, bad = 0;
  logic [34:0] ar_q[$];
  logic [33:0] r_q[$];
  logic [31:0] pend[$];
  int cred = DEPTH, err_m = 0;
  bit run_m = 0;

  always #5 aclk = ~aclk;

  axi4_bus_rd_fifos dut (
    .aclk(aclk), .aresetn(aresetn), .araddr(araddr), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .ar_rd_empty(ar_rd_empty), .ar_rd_en(ar_rd_en), .ar_addr(ar_addr), .ar_prot(ar_prot),
    .r_wr_en(r_wr_en), .r_data(r_data), .r_resp(r_resp), .r_wr_full(r_wr_full)
`ifdef AXI4_BUS_RD_FIFOS_STATS_EN
    , .rd_err_count(rd_err_count), .rd_outstanding(rd_outstanding)
`endif
  );

  task automatic idle();
    arvalid = 0; araddr = 0; arprot = 0; rready = 0;
    ar_rd_en = 0; r_wr_en = 0; r_data = 0; r_resp = 0;
  endtask

  task automatic model_reset();
    ar_q.delete(); r_q.delete(); pend.delete();
    cred = DEPTH; run_m = 0; err_m = 0;
  endtask

  // one clock: decide handshakes from model state and current inputs, then update the model
  task automatic tick();
    bit ar_hs, r_hs, ar_pop, r_push;
    logic [33:0] h;
    ar_hs  = arvalid && run_m && cred > 0;
    r_hs   = rready && r_q.size() > 0;
    ar_pop = ar_rd_en && ar_q.size() > 0;
    r_push = r_wr_en && r_q.size() < DEPTH;
    @(posedge aclk);
    #1;
    if (ar_pop) void'(ar_q.pop_front());
    if (ar_hs) ar_q.push_back({araddr, arprot});
    if (r_hs) begin
      h = r_q.pop_front();
      if (h[1:0] != 2'b00 && err_m < 65535) err_m++;
    end
    if (r_push) r_q.push_back({r_data, r_resp});
    if (ar_hs && !r_hs) cred--;
    else if (r_hs && !ar_hs && cred < DEPTH) cred++;
    run_m = 1;
  endtask

  task automatic drain();
    logic [34:0] h;
    for (int n = 0; n < 64 && (ar_q.size() > 0 || r_q.size() > 0 || pend.size() > 0); n++) begin
      idle();
      rready = 1;
      if (pend.size() > 0 && r_q.size() < DEPTH) begin
        r_wr_en = 1; r_data = pend.pop_front();
      end else if (ar_q.size() > 0 && r_q.size() < DEPTH) begin
        h = ar_q[0];
        ar_rd_en = 1; r_wr_en = 1; r_data = h[34:3];
      end
      tick();
    end
    idle();
    total++;
    if (rvalid !== 1'b0 || ar_rd_empty !== 1'b1 || arready !== 1'b1) begin
      bad++; $display("FAIL drain_idle: got rvalid=%b empty=%b arready=%b want 0 1 1", rvalid, ar_rd_empty, arready);
    end
  endtask

  task automatic test_reset();
    idle(); aresetn = 0; model_reset();
    repeat (2) @(posedge aclk);
    #1;
    total += 4;
    if (arready !== 1'b0) begin bad++; $display("FAIL reset_arready: got %b want 0", arready); end
    if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    if (ar_rd_empty !== 1'b1) begin bad++; $display("FAIL reset_ar_empty: got %b want 1", ar_rd_empty); end
    if (r_wr_full !== 1'b0) begin bad++; $display("FAIL reset_r_full: got %b want 0", r_wr_full); end
    @(negedge aclk);
    aresetn = 1;
    #1;
    total++;
    if (arready !== 1'b0) begin bad++; $display("FAIL release_arready_early: got %b want 0", arready); end
    tick();
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL release_arready: got %b want 1", arready); end
  endtask

  task automatic test_single();
    idle(); arvalid = 1; araddr = 32'h10; arprot = 3'b010;
    tick();
    idle();
    total += 2;
    if (ar_rd_empty !== 1'b0) begin bad++; $display("FAIL single_ar_empty: got %b want 0", ar_rd_empty); end
    if ({ar_addr, ar_prot} !== {32'h10, 3'b010}) begin bad++; $display("FAIL single_ar_head: got %h/%h want 10/2", ar_addr, ar_prot); end
    ar_rd_en = 1; r_wr_en = 1; r_data = 32'hDEADBEEF; r_resp = 0;
    tick();
    idle();
    total += 3;
    if (rvalid !== 1'b1) begin bad++; $display("FAIL single_rvalid: got %b want 1", rvalid); end
    if ({rdata, rresp} !== {32'hDEADBEEF, 2'b00}) begin bad++; $display("FAIL single_rdata: got %h/%h want deadbeef/0", rdata, rresp); end
    if (ar_rd_empty !== 1'b1) begin bad++; $display("FAIL single_ar_popped: got %b want 1", ar_rd_empty); end
    rready = 1;
    tick();
    idle();
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin bad++; $display("FAIL single_done: got rvalid=%b arready=%b want 0 1", rvalid, arready); end
  endtask

  task automatic test_fill();
    logic [34:0] h;
    idle();
    for (int i = 0; i < 5; i++) begin
      arvalid = 1; araddr = 32'h100 + 32'(i * 4); arprot = 3'(i);
      total++;
      if (arready !== (i < 4)) begin bad++; $display("FAIL fill_arready[%0d]: got %b want %b", i, arready, i < 4); end
      tick();
    end
    idle();
    total += 2;
    if (arready !== 1'b0) begin bad++; $display("FAIL fill_arready_after: got %b want 0", arready); end
    if (ar_q.size() != 4) begin bad++; $display("FAIL fill_accepted: got %0d want 4", ar_q.size()); end
    for (int i = 0; i < 4; i++) begin
      h = ar_q[0];
      ar_rd_en = 1; r_wr_en = 1; r_data = h[34:3] ^ 32'h5A5A0000; r_resp = 0;
      tick();
    end
    idle();
    total += 2;
    if (r_wr_full !== 1'b1) begin bad++; $display("FAIL fill_r_full: got %b want 1", r_wr_full); end
    if (ar_rd_empty !== 1'b1) begin bad++; $display("FAIL fill_ar_empty: got %b want 1", ar_rd_empty); end
    r_wr_en = 1; r_data = 32'hBADBAD00; ar_rd_en = 1;
    tick();
    idle();
    rready = 1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rvalid !== 1'b1 || rdata !== ((32'h100 + 32'(i * 4)) ^ 32'h5A5A0000)) begin
        bad++; $display("FAIL fill_beat[%0d]: got v=%b %h want 1 %h", i, rvalid, rdata, (32'h100 + 32'(i * 4)) ^ 32'h5A5A0000);
      end
      tick();
    end
    idle();
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin bad++; $display("FAIL fill_end: got rvalid=%b arready=%b want 0 1", rvalid, arready); end
  endtask

  task automatic test_credit_both();
    idle(); arvalid = 1;
    repeat (3) tick();
    idle(); ar_rd_en = 1; r_wr_en = 1; r_data = 32'h00C0FFEE;
    tick();
    idle();
    total++;
    if (arready !== 1'b1 || rvalid !== 1'b1) begin bad++; $display("FAIL credit1_setup: got arready=%b rvalid=%b want 1 1", arready, rvalid); end
    arvalid = 1; araddr = 32'h200; rready = 1;
    tick();
    idle();
    total++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin bad++; $display("FAIL credit_both: got arready=%b rvalid=%b want 1 0", arready, rvalid); end
    arvalid = 1; araddr = 32'h204;
    tick();
    idle();
    total++;
    if (arready !== 1'b0) begin bad++; $display("FAIL credit_zero: got %b want 0", arready); end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [34:0] h;
    idle(); arvalid = 1;
    repeat (2) tick();
    idle();
    repeat (2) begin
      h = ar_q[0];
      ar_rd_en = 1; r_wr_en = 1; r_data = h[34:3];
      tick();
    end
    idle();
    total++;
    if (rvalid !== 1'b1) begin bad++; $display("FAIL rmid_queued: got %b want 1", rvalid); end
    #3 aresetn = 0;
    #1;
    model_reset();
    total++;
    if (rvalid !== 1'b0 || ar_rd_empty !== 1'b1 || arready !== 1'b0) begin
      bad++; $display("FAIL rmid_async: got rvalid=%b empty=%b arready=%b want 0 1 0", rvalid, ar_rd_empty, arready);
    end
    @(posedge aclk);
    #2 aresetn = 1;
    tick();
    total++;
    if (arready !== 1'b1 || rvalid !== 1'b0 || ar_rd_empty !== 1'b1 || r_wr_full !== 1'b0) begin
      bad++; $display("FAIL rmid_after: got arready=%b rvalid=%b empty=%b full=%b want 1 0 1 0", arready, rvalid, ar_rd_empty, r_wr_full);
    end
    arvalid = 1;
    repeat (4) tick();
    idle();
    total++;
    if (arready !== 1'b0 || ar_q.size() != 4) begin bad++; $display("FAIL rmid_credit: got arready=%b accepted=%0d want 0 4", arready, ar_q.size()); end
    drain();
  endtask

`ifdef AXI4_BUS_RD_FIFOS_STATS_EN
  task automatic test_stats();
    idle(); arvalid = 1;
    repeat (4) tick();
    idle();
    total++;
    if (rd_outstanding !== 3'd4) begin bad++; $display("FAIL stats_outstanding4: got %0d want 4", rd_outstanding); end
    for (int i = 0; i < 4; i++) begin
      ar_rd_en = 1; r_wr_en = 1; r_data = 32'(i); r_resp = (i < 3) ? 2'b10 : 2'b00;
      tick();
    end
    idle(); rready = 1;
    repeat (4) tick();
    idle();
    total += 2;
    if (rd_err_count !== 16'd3) begin bad++; $display("FAIL stats_err: got %0d want 3", rd_err_count); end
    if (rd_outstanding !== 3'd0) begin bad++; $display("FAIL stats_outstanding0: got %0d want 0", rd_outstanding); end
    force dut.rd_err_count = 16'hFFFF;
    #1 release dut.rd_err_count;
    err_m = 65535;
    arvalid = 1;
    tick();
    idle(); ar_rd_en = 1; r_wr_en = 1; r_resp = 2'b11;
    tick();
    idle(); rready = 1;
    tick();
    idle();
    total++;
    if (rd_err_count !== 16'hFFFF) begin bad++; $display("FAIL stats_sat: got %h want ffff", rd_err_count); end
  endtask
`endif

  task automatic test_random();
    bit pop_ok, push_ok;
    logic [34:0] ha;
    logic [33:0] hr;
    for (int c = 0; c < 400; c++) begin
      arvalid = 1'($urandom); araddr = $urandom; arprot = 3'($urandom);
      rready = 1'($urandom); ar_rd_en = 1'($urandom);
      r_wr_en = pend.size() > 0 && 1'($urandom);
      r_data = pend.size() > 0 ? pend[0] ^ 32'hA5A5A5A5 : 32'h0;
      r_resp = 2'($urandom);
      pop_ok = ar_rd_en && ar_q.size() > 0;
      push_ok = r_wr_en && r_q.size() < DEPTH;
      if (pop_ok) begin ha = ar_q[0]; end
      tick();
      if (push_ok) void'(pend.pop_front());
      if (pop_ok) pend.push_back(ha[34:3]);
      total += 4;
      if (arready !== (run_m && cred > 0)) begin bad++; $display("FAIL rand_arready c=%0d: got %b want %b", c, arready, run_m && cred > 0); end
      if (rvalid !== (r_q.size() > 0)) begin bad++; $display("FAIL rand_rvalid c=%0d: got %b want %b", c, rvalid, r_q.size() > 0); end
      if (ar_rd_empty !== (ar_q.size() == 0)) begin bad++; $display("FAIL rand_ar_empty c=%0d: got %b want %b", c, ar_rd_empty, ar_q.size() == 0); end
      if (r_wr_full !== (r_q.size() == DEPTH)) begin bad++; $display("FAIL rand_r_full c=%0d: got %b want %b", c, r_wr_full, r_q.size() == DEPTH); end
      if (r_q.size() > 0) begin
        hr = r_q[0];
        total++;
        if ({rdata, rresp} !== hr) begin bad++; $display("FAIL rand_rhead c=%0d: got %h want %h", c, {rdata, rresp}, hr); end
      end
      if (ar_q.size() > 0) begin
        ha = ar_q[0];
        total++;
        if ({ar_addr, ar_prot} !== ha) begin bad++; $display("FAIL rand_arhead c=%0d: got %h want %h", c, {ar_addr, ar_prot}, ha); end
      end
`ifdef AXI4_BUS_RD_FIFOS_STATS_EN
      total += 2;
      if (rd_outstanding !== 3'(DEPTH - cred)) begin bad++; $display("FAIL rand_outstanding c=%0d: got %0d want %0d", c, rd_outstanding, DEPTH - cred); end
      if (rd_err_count !== 16'(err_m)) begin bad++; $display("FAIL rand_err c=%0d: got %0d want %0d", c, rd_err_count, err_m); end
`endif
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_credit_both();
    test_reset_mid();
`ifdef AXI4_BUS_RD_FIFOS_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
